// File: rtl/uart_send.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_send
// Purpose  : 8N1 UART transmitter (LSB first) with a small input FIFO.
//            Upstream pushes bytes through a valid/ready handshake. Queued
//            bytes are sent back-to-back with no idle bits between frames.
// Ports    : sys_clk    - system clock, rising edge
//            sys_rst_n  - asynchronous active-low reset
//            tx_data    - byte to enqueue
//            tx_valid   - tx_data valid this cycle
//            tx_ready   - FIFO can accept (not full), from registered state
//            uart_txd   - registered serial line, idle high
//            tx_busy    - a frame is on the line
//            tx_done    - one-cycle pulse after each stop bit completes
//            fifo_level - number of bytes currently queued
// Revision : 1.0 - initial release
// ============================================================================
module uart_send #(
  parameter int CLK_FREQUENCY = 10_000_000,
  parameter int UART_BPS      = 115200,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        uart_txd,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int              BPS_CNT   = CLK_FREQUENCY / UART_BPS;
  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0]     BAUD_LAST = 16'(BPS_CNT - 1);
  localparam logic [15:0]     BAUD_ONE  = 16'd1;
  localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
  localparam logic [AW:0]     LVL_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]     LVL_FULL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Input FIFO
  // --------------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, push, pop;
  logic [7:0]    head;

  assign full     = (count_q == LVL_FULL);
  assign empty    = (count_q == '0);
  assign push     = tx_valid && !full;
  assign head     = mem_q[rd_ptr_q];
  assign tx_ready = !full;
  assign fifo_level = count_q;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + LVL_ONE;
    else if (!push && pop) count_d = count_q - LVL_ONE;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Transmit FSM
  // --------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        done_q, done_d;
  logic        baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_end ? '0 : baud_q + BAUD_ONE;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    done_d    = 1'b0;
    pop       = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          bit_idx_d = 3'd0;
          txd_d     = shift_q[0];
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            // Next line value is the bit that becomes shift[0] after the shift.
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          done_d = 1'b1;
          // Chain straight into the next start bit so frames have no gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            txd_d   = 1'b0;
            state_d = START;
          end else begin
            txd_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      done_q    <= done_d;
    end
  end

  assign uart_txd = txd_q;
  assign tx_done  = done_q;
  assign tx_busy  = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_send.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_send
// Purpose  : Self-checking bench for uart_send at default parameters
//            (86 clocks per bit, 860 per frame). Inputs change and outputs
//            are sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_send;

  localparam int BIT   = 86;
  localparam int FRAME = 10 * BIT;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       uart_txd;
  logic       tx_busy;
  logic       tx_done;
  logic [2:0] fifo_level;

  uart_send dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .uart_txd  (uart_txd),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .fifo_level(fifo_level)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // bit 0 = start bit, bit 9 = stop bit
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] rx;
  logic       exp_line;
  int         k;
  logic [7:0] bb [8];
  int         pp [8];
  int         aa [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0)      return 1'b0;
    else if (idx == 9) return 1'b1;
    else               return b[idx-1];
  endfunction

  // Streams n bytes, byte i presented from cycle pres[i]. Cycle c is the
  // sample taken after edge E_c, E0 being the first acceptance edge. The
  // frames are expected back-to-back starting after E1.
  task automatic run_seq(input int n, input logic [7:0] bytes [8], input int pres [8],
                         input int acc_exp [8],
                         input int cp1, input int lv1, input int rd1,
                         input int cp2, input int lv2, input int rd2);
    int   nxt = 0;
    int   acc_at [8];
    bit   will;
    int   last_c = n * FRAME + 10;
    int   f, b;
    logic txd_e, busy_e, done_e;
    for (int i = 0; i < 8; i++) acc_at[i] = -1;
    for (int c = 0; c <= last_c; c++) begin
      if (nxt < n && c >= pres[nxt]) begin
        tx_valid = 1'b1;
        tx_data  = bytes[nxt];
      end else begin
        tx_valid = 1'b0;
      end
      will = tx_valid && tx_ready;
      tick();
      if (will) begin
        acc_at[nxt] = c;
        nxt++;
      end
      if (c >= 1 && c <= n * FRAME) begin
        f      = (c - 1) / FRAME;
        b      = ((c - 1) % FRAME) / BIT;
        txd_e  = frame_bit(bytes[f], b);
        busy_e = 1'b1;
      end else begin
        txd_e  = 1'b1;
        busy_e = 1'b0;
      end
      done_e = (c > 1) && ((c - 1) % FRAME == 0) && ((c - 1) / FRAME <= n);
      chk("seq_line", uart_txd, txd_e);
      chk("seq_busy", tx_busy, busy_e);
      chk("seq_done", tx_done, done_e);
      if (c == cp1) begin
        chk("seq_level_cp1", fifo_level, lv1);
        chk("seq_ready_cp1", tx_ready, rd1);
      end
      if (c == cp2) begin
        chk("seq_level_cp2", fifo_level, lv2);
        chk("seq_ready_cp2", tx_ready, rd2);
      end
    end
    tx_valid = 1'b0;
    for (int i = 0; i < n; i++) chk("seq_accept_cycle", acc_at[i], acc_exp[i]);
    chk("seq_level_end", fifo_level, 0);
  endtask

  initial begin
    vecs[0] = '{8'h55, 10'b1010101010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'hA3, 10'b1101000110};
    vecs[4] = '{8'h3C, 10'b1001111000};
    vecs[5] = '{8'hC3, 10'b1110000110};

    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    sys_rst_n = 1'b0;

    // Reset and idle
    repeat (3) @(negedge sys_clk);
    chk("rst_txd", uart_txd, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", tx_ready, 1);
    sys_rst_n = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      tick();
      chk("idle_txd", uart_txd, 1);
      chk("idle_busy", tx_busy, 0);
      chk("idle_ready", tx_ready, 1);
      chk("idle_level", fifo_level, 0);
    end

    // Single-byte frames from the vector table, also decoded mid-bit
    for (int v = 0; v < 6; v++) begin
      tx_valid = 1'b1;
      tx_data  = vecs[v].data;
      tick();
      tx_valid = 1'b0;
      chk("vec_level_after_push", fifo_level, 1);
      chk("vec_line_before_start", uart_txd, 1);
      rx = 8'h00;
      for (int c = 1; c <= FRAME + 1; c++) begin
        tick();
        exp_line = (c <= FRAME) ? vecs[v].frame[(c-1)/BIT] : 1'b1;
        chk("vec_line", uart_txd, exp_line);
        chk("vec_done", tx_done, c == FRAME + 1);
        chk("vec_busy", tx_busy, c <= FRAME);
        if ((c - 1) % BIT == BIT / 2) begin
          k = (c - 1) / BIT;
          if (k >= 1 && k <= 8) rx[k-1] = uart_txd;
        end
      end
      chk("vec_rx_byte", rx, vecs[v].data);
      repeat (5) tick();
      chk("vec_level_idle", fifo_level, 0);
      chk("vec_ready_idle", tx_ready, 1);
    end

    // Burst of six bytes with valid held high: 0x06 stalls until the
    // first STOP->START pop at E861 frees a slot, accepted on E862.
    bb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00};
    pp = '{0, 0, 0, 0, 0, 0, 0, 0};
    aa = '{0, 1, 2, 3, 4, 862, 0, 0};
    run_seq(6, bb, pp, aa, 4, 4, 0, 861, 3, 1);
    repeat (5) tick();

    // Push lands on the STOP->START pop edge with level 2: level stays 2.
    bb = '{8'hA5, 8'h5A, 8'h0F, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00};
    pp = '{0, 1, 2, 861, 0, 0, 0, 0};
    aa = '{0, 1, 2, 861, 0, 0, 0, 0};
    run_seq(4, bb, pp, aa, 860, 2, 1, 861, 2, 1);
    repeat (5) tick();

    // Reset during data bit 3 of 0xC3 with two bytes queued
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    tick();
    tx_data  = 8'h11;
    tick();
    tx_data  = 8'h22;
    tick();
    tx_valid = 1'b0;
    repeat (1 + 4 * BIT + 40 - 2) tick();
    chk("mid_line_bit3", uart_txd, 0);
    chk("mid_level", fifo_level, 2);
    chk("mid_busy", tx_busy, 1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("arst_txd", uart_txd, 1);
    chk("arst_level", fifo_level, 0);
    chk("arst_busy", tx_busy, 0);
    chk("arst_ready", tx_ready, 1);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      tick();
      chk("post_rst_txd", uart_txd, 1);
      chk("post_rst_busy", tx_busy, 0);
      chk("post_rst_done", tx_done, 0);
      chk("post_rst_level", fifo_level, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
